// File: rtl/vga_pkg.sv
// Shared definitions for the bouncing-box pattern source: coordinate width,
// axis direction encoding and the colour palette the box cycles through.
package vga_pkg;

   localparam int COORD_W = 12;

   typedef logic [0:0] dir_t;
   localparam dir_t DIR_FWD = 1'b0;
   localparam dir_t DIR_REV = 1'b1;

   // Box colours in bounce order, packed R,G,B.
   localparam logic [23:0] PALETTE [8] = '{
      24'hFFFFFF,   // white
      24'hFF0000,   // red
      24'h00FF00,   // green
      24'h0000FF,   // blue
      24'hFFFF00,   // yellow
      24'h00FFFF,   // cyan
      24'hFF00FF,   // magenta
      24'hFF8000    // orange
   };

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position plus FWD/REV direction, stepped once
// per frame and reflected off [0, limit - BOX_SIZE].
module bounce_axis
   import vga_pkg::*;
#(
   parameter int BOX_SIZE = 32,
   parameter int STEP     = 2
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_step,
   input  logic [COORD_W-1:0] i_limit,
   output logic [COORD_W-1:0] o_pos,
   output logic               o_bounce
);

   localparam logic [COORD_W:0]   BOX_W   = (COORD_W+1)'(BOX_SIZE);
   localparam logic [COORD_W:0]   STEP_W  = (COORD_W+1)'(STEP);
   localparam logic [COORD_W-1:0] BOX_N   = COORD_W'(BOX_SIZE);
   localparam logic [COORD_W-1:0] STEP_N  = COORD_W'(STEP);

   logic [COORD_W-1:0] pos_q, pos_d;
   dir_t               dir_q, dir_d;
   logic [COORD_W:0]   lim_w;
   logic [COORD_W:0]   reach_w;

   // One extra bit so pos + BOX_SIZE + STEP never wraps near 4095.
   assign lim_w   = {1'b0, i_limit};
   assign reach_w = {1'b0, pos_q} + BOX_W + STEP_W;

   always_comb begin
      pos_d    = pos_q;
      dir_d    = dir_q;
      o_bounce = 1'b0;
      if (i_step) begin
         if (lim_w < BOX_W) begin
            pos_d = '0;
         end else if (dir_q == DIR_FWD) begin
            if (reach_w > lim_w) begin
               dir_d    = DIR_REV;
               pos_d    = i_limit - BOX_N;
               o_bounce = 1'b1;
            end else begin
               pos_d = pos_q + STEP_N;
            end
         end else begin
            if (pos_q < STEP_N) begin
               dir_d    = DIR_FWD;
               pos_d    = '0;
               o_bounce = 1'b1;
            end else begin
               pos_d = pos_q - STEP_N;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pos_q <= '0;
         dir_q <= DIR_FWD;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign o_pos = pos_q;

endmodule

// File: rtl/vgabounce.sv
// Bouncing-box pixel source for the llhdmi pipeline: raster tracking, box hit
// test and a registered pixel. Optional 1-pixel white frame: VGABOUNCE_BORDER_EN.
module vgabounce
   import vga_pkg::*;
#(
   parameter int BITS_PER_COLOR = 8,
   parameter int BOX_SIZE       = 32,
   parameter int STEP           = 2,
   parameter logic [3*BITS_PER_COLOR-1:0] BG_COLOR = 24'h000040
) (
   input  logic                        i_pixclk,
   input  logic                        i_reset,
   input  logic [COORD_W-1:0]          i_width,
   input  logic [COORD_W-1:0]          i_height,
   input  logic                        i_rd,
   input  logic                        i_newline,
   input  logic                        i_newframe,
   output logic [3*BITS_PER_COLOR-1:0] o_pixel
);

   localparam int               PW    = 3 * BITS_PER_COLOR;
   localparam logic [COORD_W:0] BOX_W = (COORD_W+1)'(BOX_SIZE);

   logic [COORD_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
   logic [COORD_W-1:0] disp_x_q, disp_x_d, disp_y_q, disp_y_d;
   logic [2:0]         cidx_q, cidx_d, disp_c_q, disp_c_d;
   logic               started_q, started_d;
   logic [PW-1:0]      pixel_q, pixel_d;

   logic [COORD_W-1:0] axis_limit  [2];
   logic [COORD_W-1:0] axis_pos    [2];
   logic               axis_bounce [2];

   assign axis_limit[0] = i_width;
   assign axis_limit[1] = i_height;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         bounce_axis #(
            .BOX_SIZE (BOX_SIZE),
            .STEP     (STEP)
         ) u_axis (
            .i_clk    (i_pixclk),
            .i_reset  (i_reset),
            .i_step   (i_newframe),
            .i_limit  (axis_limit[gi]),
            .o_pos    (axis_pos[gi]),
            .o_bounce (axis_bounce[gi])
         );
      end
   endgenerate

   // A new frame draws the box where it stood before this frame's step, so
   // the drawn position and colour stay fixed for the whole frame.
   always_comb begin
      hpos_d    = hpos_q;
      vpos_d    = vpos_q;
      started_d = started_q;
      disp_x_d  = disp_x_q;
      disp_y_d  = disp_y_q;
      disp_c_d  = disp_c_q;
      cidx_d    = cidx_q;
      if (i_newframe) begin
         hpos_d    = '0;
         vpos_d    = '0;
         started_d = 1'b1;
         disp_x_d  = axis_pos[0];
         disp_y_d  = axis_pos[1];
         disp_c_d  = cidx_q;
         if (axis_bounce[0] || axis_bounce[1]) begin
            cidx_d = cidx_q + 3'd1;
         end
      end else if (i_newline) begin
         hpos_d    = '0;
         vpos_d    = vpos_q + 12'd1;
         started_d = 1'b1;
      end else if (i_rd && (hpos_q < i_width)) begin
         hpos_d = hpos_q + 12'd1;
      end
   end

   logic [COORD_W:0] h_w, v_w, bx_w, by_w;
   logic             active, in_box;

   assign h_w    = {1'b0, hpos_d};
   assign v_w    = {1'b0, vpos_d};
   assign bx_w   = {1'b0, disp_x_d};
   assign by_w   = {1'b0, disp_y_d};
   assign active = (hpos_d < i_width) && (vpos_d < i_height);
   assign in_box = (h_w >= bx_w) && (h_w < bx_w + BOX_W) &&
                   (v_w >= by_w) && (v_w < by_w + BOX_W);

`ifdef VGABOUNCE_BORDER_EN
   logic on_edge;
   assign on_edge = (hpos_d == '0) || (hpos_d == i_width - 12'd1) ||
                    (vpos_d == '0) || (vpos_d == i_height - 12'd1);
`endif

   always_comb begin
      pixel_d = '0;
      if (started_d && active) begin
`ifdef VGABOUNCE_BORDER_EN
         if (on_edge) begin
            pixel_d = '1;
         end else if (in_box) begin
            pixel_d = PW'(PALETTE[disp_c_d]);
         end else begin
            pixel_d = BG_COLOR;
         end
`else
         if (in_box) begin
            pixel_d = PW'(PALETTE[disp_c_d]);
         end else begin
            pixel_d = BG_COLOR;
         end
`endif
      end
   end

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         hpos_q    <= '0;
         vpos_q    <= '0;
         disp_x_q  <= '0;
         disp_y_q  <= '0;
         disp_c_q  <= '0;
         cidx_q    <= '0;
         started_q <= 1'b0;
         pixel_q   <= '0;
      end else begin
         hpos_q    <= hpos_d;
         vpos_q    <= vpos_d;
         disp_x_q  <= disp_x_d;
         disp_y_q  <= disp_y_d;
         disp_c_q  <= disp_c_d;
         cidx_q    <= cidx_d;
         started_q <= started_d;
         pixel_q   <= pixel_d;
      end
   end

   assign o_pixel = pixel_q;

endmodule

// File: tb/tb_vgabounce.sv
// Self-checking bench for vgabounce: constant-expectation sequences plus random
// strobes against a frame-level model. Honours VGABOUNCE_BORDER_EN when defined.
module tb_vgabounce;

   localparam int          BOX = 32;
   localparam int          STP = 2;
   localparam logic [23:0] BG  = 24'h000040;
   localparam logic [23:0] WHITE = 24'hFFFFFF;
   localparam logic [23:0] RED   = 24'hFF0000;
`ifdef VGABOUNCE_BORDER_EN
   localparam bit          BORDER = 1'b1;
   localparam logic [23:0] EDGE   = 24'hFFFFFF;
`else
   localparam bit          BORDER = 1'b0;
   localparam logic [23:0] EDGE   = 24'h000040;
`endif
   localparam logic [23:0] PAL [8] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                                       24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'hFF8000};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        nf = 1'b0, nl = 1'b0, rd = 1'b0;
   logic [11:0] w = 12'd640, h = 12'd480;
   logic [23:0] pix;

   always #5 clk = ~clk;

   vgabounce dut (
      .i_pixclk   (clk),
      .i_reset    (rst),
      .i_width    (w),
      .i_height   (h),
      .i_rd       (rd),
      .i_newline  (nl),
      .i_newframe (nf),
      .o_pixel    (pix)
   );

   int n_pass = 0;
   int n_total = 0;

   // Model: box position and velocity sign per axis, colour counter, and the
   // box/colour captured at the start of the frame being drawn.
   int mw, mh, m_h, m_v, m_bx, m_by, m_dx, m_dy, m_c, m_dbx, m_dby, m_dc;
   bit m_on;

   function automatic logic [23:0] model_pixel();
      if (!m_on || m_h >= mw || m_v >= mh) return 24'h0;
      if (BORDER && (m_h == 0 || m_h == mw - 1 || m_v == 0 || m_v == mh - 1)) return 24'hFFFFFF;
      if (m_h >= m_dbx && m_h < m_dbx + BOX && m_v >= m_dby && m_v < m_dby + BOX) return PAL[m_dc];
      return BG;
   endfunction

   function automatic void axis_move(inout int pos, inout int dir, input int lim, output bit hit);
      hit = 1'b0;
      if (lim < BOX) begin
         pos = 0;
      end else if (dir > 0 && pos + BOX + STP > lim) begin
         dir = -1; pos = lim - BOX; hit = 1'b1;
      end else if (dir < 0 && pos < STP) begin
         dir = 1; pos = 0; hit = 1'b1;
      end else begin
         pos = pos + dir * STP;
      end
   endfunction

   task automatic model_step(input bit f, input bit l, input bit r);
      bit hx, hy;
      if (f) begin
         m_dbx = m_bx; m_dby = m_by; m_dc = m_c;
         axis_move(m_bx, m_dx, mw, hx);
         axis_move(m_by, m_dy, mh, hy);
         if (hx || hy) m_c = (m_c + 1) % 8;
         m_h = 0; m_v = 0; m_on = 1'b1;
      end else if (l) begin
         m_h = 0; m_v = (m_v + 1) % 4096; m_on = 1'b1;
      end else if (r && m_h < mw) begin
         m_h = m_h + 1;
      end
   endtask

   task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at (%0d,%0d): got %h expected %h", name, m_h, m_v, got, exp);
   endtask

   task automatic nchk(input string name, input logic [23:0] exp);
      check(name, pix, exp);
      $display("check %-14s (%0d,%0d) pixel %h expected %h", name, m_h, m_v, pix, exp);
   endtask

   // One clock with the given strobes; the model-predicted pixel is compared every cycle.
   task automatic cyc(input bit f, input bit l, input bit r);
      nf = f; nl = l; rd = r;
      @(posedge clk);
      model_step(f, l, r);
      #1;
      nf = 1'b0; nl = 1'b0; rd = 1'b0;
      check("pix", pix, model_pixel());
   endtask

   task automatic do_reset(input int wv, input int hv);
      w = 12'(wv); h = 12'(hv);
      rst = 1'b1;
      #1;
      nchk("rst_async", 24'h0);
      @(posedge clk);
      #1;
      nchk("rst_hold", 24'h0);
      rst = 1'b0;
      mw = wv; mh = hv; m_h = 0; m_v = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
      m_c = 0; m_dbx = 0; m_dby = 0; m_dc = 0; m_on = 1'b0;
   endtask

   task automatic read_to(input int x);
      for (int i = 0; i < 4096 && m_h < x; i++) cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic rows(input int n);
      repeat (n) cyc(1'b0, 1'b1, 1'b0);
   endtask

   typedef struct {
      bit          f;
      bit          l;
      bit          r;
      int          rep;
      logic [23:0] exp;
   } vec_t;

   vec_t tbl [6];

   initial begin
      // Frame 0 on 640x480: box drawn at the origin in white.
      tbl[0] = '{f: 1'b1, l: 1'b0, r: 1'b0, rep: 1,   exp: WHITE};
      tbl[1] = '{f: 1'b0, l: 1'b0, r: 1'b1, rep: 31,  exp: WHITE};
      tbl[2] = '{f: 1'b0, l: 1'b0, r: 1'b1, rep: 607, exp: EDGE};
      tbl[3] = '{f: 1'b0, l: 1'b0, r: 1'b1, rep: 1,   exp: EDGE};
      tbl[4] = '{f: 1'b0, l: 1'b0, r: 1'b1, rep: 1,   exp: 24'h0};
      tbl[5] = '{f: 1'b0, l: 1'b0, r: 1'b1, rep: 1,   exp: 24'h0};

      do_reset(640, 480);
      repeat (3) begin
         cyc(1'b0, 1'b0, 1'b1);
         nchk("idle_rd", 24'h0);
      end

      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < tbl[t].rep; k++) begin
            cyc(tbl[t].f, tbl[t].l, tbl[t].r);
            check("frame0_tbl", pix, tbl[t].exp);
         end
         $display("row %0d: %0d strobes f=%0d l=%0d r=%0d -> pixel %h", t, tbl[t].rep,
                  tbl[t].f, tbl[t].l, tbl[t].r, pix);
      end
      rows(200);
      nchk("border_0_200", EDGE);
      read_to(639);
      nchk("border_639", EDGE);

      // Reset in the middle of a line with the box well away from the origin.
      do_reset(640, 480);
      repeat (50) cyc(1'b1, 1'b0, 1'b0);
      rows(100);
      read_to(100);
      nchk("pre_reset", WHITE);
      do_reset(640, 480);
      cyc(1'b1, 1'b0, 1'b0);
      nchk("post_rst_org", WHITE);
      cyc(1'b1, 1'b0, 1'b0);
      rows(2);
      read_to(1);
      nchk("post_rst_1_2", BG);
      cyc(1'b0, 1'b0, 1'b1);
      nchk("post_rst_2_2", WHITE);

      // Simultaneous strobes.
      do_reset(640, 480);
      cyc(1'b1, 1'b1, 1'b1);
      nchk("simul_origin", WHITE);
      cyc(1'b1, 1'b0, 1'b0);
      nchk("simul_0_0", EDGE);
      rows(2);
      read_to(1);
      nchk("simul_1_2", BG);
      cyc(1'b0, 1'b0, 1'b1);
      nchk("simul_once", WHITE);
      read_to(5);
      cyc(1'b0, 1'b1, 1'b1);
      nchk("nl_rd_h0", EDGE);
      cyc(1'b0, 1'b0, 1'b1);
      nchk("nl_rd_h1", BG);

      // Right edge; a height below BOX_SIZE pins the box to row 0.
      do_reset(640, 16);
      repeat (303) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0); rows(1);
      read_to(605); nchk("re_605", BG);
      read_to(606); nchk("re_606", WHITE);
      cyc(1'b1, 1'b0, 1'b0); rows(1);
      read_to(607); nchk("re_607", BG);
      read_to(608); nchk("re_608", WHITE);
      cyc(1'b1, 1'b0, 1'b0); rows(1);
      read_to(607); nchk("re_rev_607", BG);
      read_to(608); nchk("re_rev_608", RED);
      cyc(1'b1, 1'b0, 1'b0); rows(1);
      read_to(605); nchk("re_back_605", BG);
      read_to(606); nchk("re_back_606", RED);

      // Corner: both axes bounce on the same frame, colour advances by one.
      do_reset(64, 64);
      repeat (18) cyc(1'b1, 1'b0, 1'b0);
      rows(32);
      read_to(31); nchk("corner_31", BG);
      read_to(32); nchk("corner_red", RED);

      // Random strobes over random active areas, some narrower than the box.
      for (int c = 0; c < 3; c++) begin
         do_reset($urandom_range(8, 120), $urandom_range(8, 90));
         $display("random config %0d: %0dx%0d", c, mw, mh);
         for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 20)       cyc(1'b1, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            else if (r < 70)  cyc(1'b0, 1'b1, $urandom_range(0, 1) != 0);
            else if (r < 800) cyc(1'b0, 1'b0, 1'b1);
            else              cyc(1'b0, 1'b0, 1'b0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
